// File: rtl/regfile_sb_if.sv
// Purpose : bundles the operand/debug read, writeback, scoreboard and clear signals of regfile_sb.
// Latency : reads are combinational; writes, busy updates and the clear start take effect on the next clk edge.
// Backpressure: none; clr_busy tells the master that writes, sb_set and clr_req are being ignored.
// Ports   : master = decode/issue/writeback side, slave = register file.
interface regfile_sb_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic [AW-1:0]    rd_addr0;
   logic [AW-1:0]    rd_addr1;
   logic [WIDTH-1:0] rd_data0;
   logic [WIDTH-1:0] rd_data1;
   logic             hazard0;
   logic             hazard1;
   logic [AW-1:0]    dbg_addr;
   logic [WIDTH-1:0] dbg_data;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             sb_set;
   logic [AW-1:0]    sb_addr;
   logic             clr_req;
   logic             clr_busy;

   modport master (
      output rd_addr0, rd_addr1, dbg_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clr_req,
      input  rd_data0, rd_data1, hazard0, hazard1, dbg_data, clr_busy
   );

   modport slave (
      input  rd_addr0, rd_addr1, dbg_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clr_req,
      output rd_data0, rd_data1, hazard0, hazard1, dbg_data, clr_busy
   );
endinterface

// File: rtl/regfile_sb.sv
// Purpose : 2**AW x WIDTH register file with per-register busy scoreboard and sequential bulk clear.
// Latency : reads 0 cycles (combinational); writes/busy visible the cycle after the edge; clear takes 2**AW cycles.
// Backpressure: while clr_busy=1, wr_en, sb_set and clr_req are dropped, reads stay live.
// Ports   : clk, reset (async, active-low), bus (regfile_sb_if.slave: 2 operand reads with hazard,
//           debug read, write port, scoreboard set, clear request/busy).
// Option  : define REGFILE_BYPASS_EN to forward same-cycle write data/hazard=0 to the operand ports.
module regfile_sb #(
   parameter int WIDTH    = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic        clk,
   input  logic        reset,
   regfile_sb_if.slave bus
);
   localparam int DEPTH = 1 << AW;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic             wr_ok, sb_ok;
   logic             byp0, byp1;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Register 0 is hard-wired when ZERO_REG is set, so its traffic is filtered here once.
   assign wr_ok = bus.wr_en  && !is_zero(bus.wr_addr);
   assign sb_ok = bus.sb_set && !is_zero(bus.sb_addr);

`ifdef REGFILE_BYPASS_EN
   // Forwarding only happens when the write would actually be accepted this cycle.
   assign byp0 = reset && (state_q == IDLE) && wr_ok && (bus.wr_addr == bus.rd_addr0);
   assign byp1 = reset && (state_q == IDLE) && wr_ok && (bus.wr_addr == bus.rd_addr1);
`else
   assign byp0 = 1'b0;
   assign byp1 = 1'b0;
`endif

   // State register: FSM, clear counter, storage and busy bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      case (state_q)
         IDLE: begin
            if (wr_ok) begin
               mem_d[bus.wr_addr]  = bus.wr_data;
               busy_d[bus.wr_addr] = 1'b0;
            end
            // Applied after the write clear so an issue to the same register keeps it busy.
            if (sb_ok) busy_d[bus.sb_addr] = 1'b1;
            if (bus.clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            mem_d[cnt_q]  = '0;
            busy_d[cnt_q] = 1'b0;
            cnt_d         = cnt_q + 1'b1;  // wraps to 0 on the terminal entry
            if (&cnt_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      bus.clr_busy = (state_q == CLEAR);
      bus.rd_data0 = is_zero(bus.rd_addr0) ? '0 : mem_q[bus.rd_addr0];
      bus.rd_data1 = is_zero(bus.rd_addr1) ? '0 : mem_q[bus.rd_addr1];
      bus.hazard0  = is_zero(bus.rd_addr0) ? 1'b0 : busy_q[bus.rd_addr0];
      bus.hazard1  = is_zero(bus.rd_addr1) ? 1'b0 : busy_q[bus.rd_addr1];
      bus.dbg_data = is_zero(bus.dbg_addr) ? '0 : mem_q[bus.dbg_addr];
      if (byp0) begin
         bus.rd_data0 = bus.wr_data;
         bus.hazard0  = 1'b0;
      end
      if (byp1) begin
         bus.rd_data1 = bus.wr_data;
         bus.hazard1  = 1'b0;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
   localparam int WIDTH = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int ZR    = 1;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   regfile_sb_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
   regfile_sb #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZR)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;

   // Reference model: plain arrays of register contents and busy flags.
   logic [31:0] m_mem [DEPTH];
   logic        m_busy[DEPTH];

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = '0;
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic logic is_r0(input logic [4:0] a);
      return (ZR != 0) && (a == 5'd0);
   endfunction

   function automatic logic bypass_hit(input logic [4:0] a);
      return BYP && bus.wr_en && (bus.wr_addr == a) && !is_r0(a);
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (is_r0(a)) return '0;
      if (bypass_hit(a)) return bus.wr_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_hz(input logic [4:0] a);
      if (is_r0(a)) return 1'b0;
      if (bypass_hit(a)) return 1'b0;
      return m_busy[a];
   endfunction

   // Effect of one rising edge in IDLE: write clears busy, an issue to the same register wins.
   function automatic void model_edge();
      if (bus.wr_en && !is_r0(bus.wr_addr)) begin
         m_mem[bus.wr_addr] = bus.wr_data;
         m_busy[bus.wr_addr] = 1'b0;
      end
      if (bus.sb_set && !is_r0(bus.sb_addr)) m_busy[bus.sb_addr] = 1'b1;
   endfunction

   task automatic idle();
      bus.rd_addr0 = '0; bus.rd_addr1 = '0; bus.dbg_addr = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.sb_set = 1'b0; bus.sb_addr = '0; bus.clr_req = 1'b0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic fill_all();
      for (int i = 1; i < DEPTH; i++) begin
         bus.wr_en = 1'b1; bus.wr_addr = 5'(i); bus.wr_data = $urandom() | 32'h1;
         bus.sb_set = (i % 3 == 0); bus.sb_addr = 5'((i + 5) % DEPTH);
         step();
      end
      idle();
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_addr0 = 5'(i); bus.rd_addr1 = 5'(i); bus.dbg_addr = 5'(i);
         #1;
         checks++;
         if (bus.rd_data0 !== 32'h0 || bus.dbg_data !== 32'h0 || bus.hazard0 !== 1'b0 || bus.hazard1 !== 1'b0) begin
            failures++;
            $display("FAIL %s addr=%0d got rd0=%h dbg=%h hz0=%b hz1=%b exp all 0", tag, i, bus.rd_data0, bus.dbg_data, bus.hazard0, bus.hazard1);
         end
      end
      idle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      write(5'd1, 32'h1111_1111);
      write(5'd2, 32'h2222_2222);
      bus.sb_set = 1'b1; bus.sb_addr = 5'd6;
      step();
      idle();
      reset = 1'b0;
      bus.rd_addr0 = 5'd1; bus.rd_addr1 = 5'd6; bus.dbg_addr = 5'd2;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'hCAFE_F00D;
      #1;
      checks++;
      if (bus.rd_data0 !== 32'h0 || bus.rd_data1 !== 32'h0 || bus.dbg_data !== 32'h0 ||
          bus.hazard0 !== 1'b0 || bus.hazard1 !== 1'b0 || bus.clr_busy !== 1'b0) begin
         failures++;
         $display("FAIL in_reset got rd0=%h rd1=%h dbg=%h hz0=%b hz1=%b cb=%b exp all 0",
                  bus.rd_data0, bus.rd_data1, bus.dbg_data, bus.hazard0, bus.hazard1, bus.clr_busy);
      end
      idle();
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (bus.clr_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_clr_busy got=%b exp=0", bus.clr_busy);
      end
      check_all_zero("reset_regs");
   endtask

   task automatic test_write();
      write(5'd5, 32'hDEAD_BEEF);
      bus.rd_addr0 = 5'd5;
      #1;
      checks++;
      if (bus.rd_data0 !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL wr5 got=%h exp=deadbeef", bus.rd_data0);
      end
      write(5'd0, 32'h0000_1234);
      bus.rd_addr1 = 5'd0;
      #1;
      checks++;
      if (bus.rd_data1 !== 32'h0) begin
         failures++;
         $display("FAIL wr0_dropped got=%h exp=0", bus.rd_data1);
      end
      for (int n = 0; n < 60; n++) begin
         bus.wr_en = $urandom_range(0, 1); bus.wr_addr = 5'($urandom_range(0, 31)); bus.wr_data = $urandom();
         bus.rd_addr0 = ($urandom_range(0, 2) == 0) ? bus.wr_addr : 5'($urandom_range(0, 31));
         bus.rd_addr1 = 5'($urandom_range(0, 31)); bus.dbg_addr = bus.wr_addr;
         #1;
         checks++;
         if (bus.rd_data0 !== exp_rd(bus.rd_addr0) || bus.rd_data1 !== exp_rd(bus.rd_addr1) ||
             bus.dbg_data !== (is_r0(bus.dbg_addr) ? 32'h0 : m_mem[bus.dbg_addr])) begin
            failures++;
            $display("FAIL rand_wr n=%0d got rd0=%h rd1=%h dbg=%h exp rd0=%h rd1=%h", n,
                     bus.rd_data0, bus.rd_data1, bus.dbg_data, exp_rd(bus.rd_addr0), exp_rd(bus.rd_addr1));
         end
         step();
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] last;
      for (int n = 0; n < 4; n++) begin
         last = $urandom();
         write(5'd12, last);
      end
      bus.rd_addr1 = 5'd12;
      #1;
      checks++;
      if (bus.rd_data1 !== last || bus.rd_data1 !== m_mem[12]) begin
         failures++;
         $display("FAIL b2b got=%h exp=%h", bus.rd_data1, last);
      end
      idle();
   endtask

   task automatic test_scoreboard();
      bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
      step();
      idle();
      bus.rd_addr1 = 5'd7;
      #1;
      checks++;
      if (bus.hazard1 !== 1'b1) begin
         failures++;
         $display("FAIL sb_set7 got=%b exp=1", bus.hazard1);
      end
      write(5'd7, 32'h55);
      bus.rd_addr1 = 5'd7;
      #1;
      checks++;
      if (bus.hazard1 !== 1'b0 || bus.rd_data1 !== 32'h55) begin
         failures++;
         $display("FAIL wr7_clears got hz=%b data=%h exp hz=0 data=55", bus.hazard1, bus.rd_data1);
      end
      bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h9999;
      step();
      idle();
      bus.rd_addr1 = 5'd9; bus.dbg_addr = 5'd9;
      #1;
      checks++;
      if (bus.hazard1 !== 1'b1 || bus.dbg_data !== 32'h9999) begin
         failures++;
         $display("FAIL set_wins got hz=%b dbg=%h exp hz=1 dbg=9999", bus.hazard1, bus.dbg_data);
      end
      bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
      step();
      idle();
      #1;
      checks++;
      if (bus.hazard0 !== 1'b0) begin
         failures++;
         $display("FAIL sb_r0 got=%b exp=0", bus.hazard0);
      end
      for (int n = 0; n < 80; n++) begin
         bus.wr_en = $urandom_range(0, 1); bus.wr_addr = 5'($urandom_range(0, 15)); bus.wr_data = $urandom();
         bus.sb_set = $urandom_range(0, 1); bus.sb_addr = 5'($urandom_range(0, 15));
         bus.rd_addr0 = 5'($urandom_range(0, 15)); bus.rd_addr1 = 5'($urandom_range(0, 15));
         #1;
         checks++;
         if (bus.hazard0 !== exp_hz(bus.rd_addr0) || bus.hazard1 !== exp_hz(bus.rd_addr1) ||
             bus.rd_data0 !== exp_rd(bus.rd_addr0) || bus.rd_data1 !== exp_rd(bus.rd_addr1)) begin
            failures++;
            $display("FAIL rand_sb n=%0d got hz0=%b hz1=%b rd0=%h rd1=%h exp hz0=%b hz1=%b rd0=%h rd1=%h", n,
                     bus.hazard0, bus.hazard1, bus.rd_data0, bus.rd_data1,
                     exp_hz(bus.rd_addr0), exp_hz(bus.rd_addr1), exp_rd(bus.rd_addr0), exp_rd(bus.rd_addr1));
         end
         step();
      end
      idle();
   endtask

   task automatic test_bypass();
      logic [31:0] old3;
      bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
      step();
      idle();
      old3 = m_mem[3];
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5A5_A5A5;
      bus.rd_addr0 = 5'd3; bus.dbg_addr = 5'd3;
      #1;
      checks++;
      if (bus.rd_data0 !== (BYP ? 32'hA5A5_A5A5 : old3) || bus.hazard0 !== !BYP || bus.dbg_data !== old3) begin
         failures++;
         $display("FAIL byp_same got rd0=%h hz0=%b dbg=%h exp rd0=%h hz0=%b dbg=%h", bus.rd_data0, bus.hazard0,
                  bus.dbg_data, BYP ? 32'hA5A5_A5A5 : old3, !BYP, old3);
      end
      step();
      idle();
      bus.rd_addr0 = 5'd3;
      #1;
      checks++;
      if (bus.rd_data0 !== 32'hA5A5_A5A5 || bus.hazard0 !== 1'b0) begin
         failures++;
         $display("FAIL byp_next got rd0=%h hz0=%b exp a5a5a5a5/0", bus.rd_data0, bus.hazard0);
      end
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF; bus.rd_addr1 = 5'd0;
      #1;
      checks++;
      if (bus.rd_data1 !== 32'h0 || bus.hazard1 !== 1'b0) begin
         failures++;
         $display("FAIL byp_r0 got rd1=%h hz1=%b exp 0/0", bus.rd_data1, bus.hazard1);
      end
      step();
      idle();
   endtask

   task automatic test_clear();
      int n;
      logic [31:0] e_d;
      logic e_h;
      fill_all();
      bus.clr_req = 1'b1;
      step();
      idle();
      n = 0;
      while (bus.clr_busy === 1'b1 && n < 100) begin
         bus.wr_en = 1'b1; bus.wr_addr = 5'($urandom_range(1, 31)); bus.wr_data = $urandom();
         bus.sb_set = 1'b1; bus.sb_addr = 5'($urandom_range(1, 31)); bus.clr_req = $urandom_range(0, 1);
         bus.rd_addr0 = bus.wr_addr; bus.dbg_addr = 5'($urandom_range(0, 31));
         #1;
         // n entries (from address 0 upward) have been zeroed so far; writes are ignored.
         e_d = (is_r0(bus.dbg_addr) || int'(bus.dbg_addr) < n) ? 32'h0 : m_mem[bus.dbg_addr];
         e_h = (is_r0(bus.rd_addr0) || int'(bus.rd_addr0) < n) ? 1'b0 : m_busy[bus.rd_addr0];
         checks++;
         if (bus.dbg_data !== e_d || bus.hazard0 !== e_h ||
             bus.rd_data0 !== ((int'(bus.rd_addr0) < n) ? 32'h0 : m_mem[bus.rd_addr0])) begin
            failures++;
            $display("FAIL clr_partial n=%0d got dbg=%h hz0=%b rd0=%h exp dbg=%h hz0=%b", n,
                     bus.dbg_data, bus.hazard0, bus.rd_data0, e_d, e_h);
         end
         @(posedge clk);
         #1;
         n++;
      end
      idle();
      checks++;
      if (n != DEPTH) begin
         failures++;
         $display("FAIL clr_len got=%0d cycles exp=%0d", n, DEPTH);
      end
      model_reset();
      check_all_zero("clr_regs");
      write(5'd4, 32'h4444_0000);
      bus.rd_addr0 = 5'd4;
      #1;
      checks++;
      if (bus.rd_data0 !== 32'h4444_0000 || bus.clr_busy !== 1'b0) begin
         failures++;
         $display("FAIL clr_idle_after got rd0=%h cb=%b exp 44440000/0", bus.rd_data0, bus.clr_busy);
      end
      idle();
   endtask

   task automatic test_reset_mid_clear();
      fill_all();
      bus.clr_req = 1'b1;
      step();
      idle();
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.clr_busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_clr_busy got=%b exp=1", bus.clr_busy);
      end
      reset = 1'b0;
      bus.dbg_addr = 5'd20;
      #1;
      checks++;
      if (bus.clr_busy !== 1'b0 || bus.dbg_data !== 32'h0) begin
         failures++;
         $display("FAIL mid_clr_reset got cb=%b dbg=%h exp 0/0", bus.clr_busy, bus.dbg_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle k=%0d got=%b exp=0", k, bus.clr_busy);
         end
      end
      check_all_zero("mid_clr_regs");
      write(5'd20, 32'h2020_2020);
      bus.rd_addr1 = 5'd20;
      #1;
      checks++;
      if (bus.rd_data1 !== 32'h2020_2020) begin
         failures++;
         $display("FAIL post_reset_wr got=%h exp=20202020", bus.rd_data1);
      end
      idle();
   endtask

   initial begin
      idle();
      model_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      test_reset();
      test_write();
      test_back_to_back();
      test_scoreboard();
      test_bypass();
      test_clear();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with scoreboard and sequential bulk-clear, the next-generation register file for the datapath. It provides two operand read ports, one debug read port and one write port, all sized by parameter. A per-register pending-write (busy) bit lets issue logic detect read-after-write hazards. A clear state machine zeroes the whole file on request without a reset. It sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- WIDTH, 32, data width in bits
- AW, 5, address width; depth = 2**AW registers
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr0, rd_addr1  in  AW  operand read addresses
- rd_data0, rd_data1  out  WIDTH  operand read data (combinational)
- hazard0, hazard1  out  1  addressed register has a pending write
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  debug read data (combinational, never bypassed)
- wr_en  in  1  write strobe from writeback
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- sb_set  in  1  issue strobe: mark sb_addr busy
- sb_addr  in  AW  destination register of issued instruction
- clr_req  in  1  start a bulk clear
- clr_busy  out  1  bulk clear in progress

## Operation
- Storage: 2**AW x WIDTH registers plus 2**AW busy bits.
- Reset (reset low, asynchronous): all registers 0, all busy bits 0, FSM IDLE, clear counter 0, clr_busy 0. While reset is low, all read data outputs are 0 and hazard outputs are 0.
- Write: when wr_en=1 in IDLE, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. Writes to register 0 are dropped when ZERO_REG=1.
- Scoreboard set: when sb_set=1 in IDLE, busy[sb_addr] <= 1. With ZERO_REG=1, address 0 is ignored.
- If sb_set and wr_en target the same address in one cycle, the set wins and the busy bit ends at 1. The data write still happens.
- hazardN = busy[rd_addrN], except as modified by the bypass (see Configuration). hazardN is always 0 for address 0 when ZERO_REG=1.
- Clear FSM states:
  - IDLE: on clr_req=1, go to CLEAR with counter=0.
  - CLEAR: each cycle reg[counter] <= 0, busy[counter] <= 0, counter++. When counter = 2**AW-1, write that entry and return to IDLE with counter=0.
- clr_busy = (state == CLEAR).
- During CLEAR, wr_en, sb_set and clr_req are ignored. Reads remain live and return partially cleared contents.
- Reset asserted mid-CLEAR aborts the clear immediately and applies the full reset state.

## Timing
- Read latency 0: rd_data, dbg_data and hazard are combinational from addresses and state.
- Write and busy updates are visible on reads in the cycle after the rising edge that takes them.
- A clr_req sampled at edge E sets clr_busy after E. clr_busy stays high for exactly 2**AW cycles, then IDLE resumes.
- Counter wrap: the counter is AW bits wide and returns to 0 on the terminal entry. The FSM exits CLEAR at the same edge.
- Back-to-back writes to the same address: last write wins, one per cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Applies when wr_en=1 in IDLE and wr_addr == rd_addrN, excluding address 0 when ZERO_REG=1.
  - rd_dataN = wr_data in the same cycle.
  - hazardN = 0 in the same cycle.
  - The debug port is never bypassed.
- REGFILE_BYPASS_EN undefined:
  - rd_dataN returns the stored value.
  - hazardN reflects the stored busy bit.
  - The new value appears one cycle later.

## Test plan
- Reset with registers pre-written, then release reset: all 32 registers read 0, hazard0/1=0, clr_busy=0.
- Write reg 5 = 0xDEADBEEF, then read rd_addr0=5 next cycle: rd_data0=0xDEADBEEF. Write reg 0 = 0x1234 with ZERO_REG=1: rd_data1 at addr 0 reads 0.
- sb_set addr 7, then rd_addr1=7: hazard1=1. wr_en to addr 7 with 0x55: next cycle hazard1=0 and rd_data1=0x55. sb_set and wr_en both on addr 9 in one cycle: hazard stays 1.
- Bypass with the macro defined: wr_en addr 3 = 0xA5A5A5A5 with rd_addr0=3 in the same cycle gives rd_data0=0xA5A5A5A5 and hazard0=0 that cycle. Without the macro, the old value is read that cycle and the new value the next cycle.
- Pulse clr_req with all registers nonzero and some busy bits set: clr_busy high exactly 32 cycles, wr_en during the clear has no effect, then all registers read 0 and all hazards are 0.
- Assert reset at clear cycle 10: clr_busy drops immediately, the FSM is IDLE after release, and all registers read 0.
